alarm_clock_alarm_bank: RTL and testbench
=========================================

Name: alarm_clock_alarm_bank

Overview:
- Register-side alarm store generalised from one alarm to ALARM_CNT independent slots.
- Accepts set/unset writes per slot and watches the current POSIX time.
- Raises a one-shot fire pulse per slot when that slot's alarm time is reached.
- Forwards the earliest pending alarm to the single-alarm POSIX time control path (usr_posix_time / usr_posix_time_en / usr_unset_alarm semantics). Sits between the CSR block and the alarm comparator.

Parameters:
ALARM_CNT, 4, number of alarm slots (1..16)
TIME_W, 32, POSIX time width in bits
IDX_W, $clog2(ALARM_CNT) (min 1), slot index width

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
wr_valid_i  in  1  write request
wr_ready_o  out  1  write accept; transfer occurs when wr_valid_i && wr_ready_o at clk edge
wr_idx_i  in  IDX_W  target slot
wr_unset_i  in  1  0 = set (arm with wr_time_i), 1 = unset (disarm)
wr_time_i  in  TIME_W  alarm time for set
cur_time_i  in  TIME_W  current POSIX time
cur_time_val_i  in  1  cur_time_i valid strobe (typically 1 Hz)
armed_o  out  ALARM_CNT  per-slot armed flags
fire_o  out  ALARM_CNT  one-cycle per-slot fire pulse
usr_posix_time_o  out  TIME_W  earliest pending alarm time
usr_posix_time_en_o  out  1  one-cycle strobe: usr_posix_time_o is new
usr_unset_alarm_o  out  1  one-cycle strobe: no alarm pending

Behaviour:
- Reset (rst_i high at edge): all slots disarmed with time 0; cur_time_q=0; pend=0; pushed_vld=0; state=IDLE. Every output is 0 in the cycle after a reset edge, except wr_ready_o, which is 1. Reset mid-scan aborts the scan with no pulses.
- State machine: IDLE -> SCAN -> UPDATE -> IDLE. wr_ready_o = (state==IDLE), registered.
- IDLE:
  - On an accepted write, apply it at that edge. Set stores the time and arms the slot (overwrites if already armed). Unset disarms the slot.
  - If wr_idx_i >= ALARM_CNT, the write is accepted and ignored.
  - On cur_time_val_i, latch cur_time_q.
  - Either event, or pend=1, clears pend and enters SCAN with idx=0, best=all-ones, found=0.
- cur_time_val_i outside IDLE: latch cur_time_q immediately (latest value wins) and set pend=1. This forces one more scan after returning to IDLE.
- SCAN: one slot per cycle, idx 0..ALARM_CNT-1.
  - If armed and time <= cur_time_q, disarm the slot and assert fire_o[idx] (registered, next cycle).
  - Else if armed and time < best, set best=time and found=1. Strict < means the lowest index wins ties.
  - After idx=ALARM_CNT-1, go to UPDATE.
- UPDATE, one cycle, with outputs registered:
  - If found && (!pushed_vld || best != usr_posix_time_o): load usr_posix_time_o=best, pulse usr_posix_time_en_o, set pushed_vld=1.
  - Else if !found && pushed_vld: pulse usr_unset_alarm_o, clear pushed_vld. usr_posix_time_o holds its value.
  - Otherwise no strobe. Strobes never repeat for an unchanged result.
- Latency: write or strobe accepted at edge 0. Scan occupies cycles 1..ALARM_CNT. UPDATE is cycle ALARM_CNT+1. The en/unset strobe and wr_ready_o=1 appear in cycle ALARM_CNT+2.
- A write and cur_time_val_i in the same IDLE cycle are both taken, and one scan covers both.
- Before any time strobe, cur_time_q=0, so a slot set to time 0 fires on its first scan.
- Comparisons are unsigned TIME_W-bit. No wrap handling: times are absolute POSIX.
- armed_o reflects the slot flags directly (registered state).

Test Plan:
- Reset, ALARM_CNT=4 -> armed_o=0, fire_o=0, strobes 0, wr_ready_o=1; cur_time 100 strobe -> scan completes with no strobes.
- cur_time=100; set slot2=500, then slot0=300 -> first write: en pulse with usr_posix_time_o=500 at cycle 6; second: en pulse with 300; armed_o=4'b0101.
- Then cur_time_val with 300 -> fire_o[0] pulse once, armed_o=4'b0100, en pulse with 500; cur_time 301 -> no fire, no strobe.
- Unset slot2 as the last armed slot -> usr_unset_alarm_o one pulse, armed_o=0; repeat unset -> no strobe.
- Set slot1=slot3=700 -> a single en with 700; at cur_time 800, fire_o[1] and fire_o[3] pulse on separate cycles, then unset strobe.
- Hold wr_valid_i with cur_time_val_i pulsed mid-scan -> wr_ready_o low during scan; pend causes a second scan; write accepted only in IDLE; idx=5 with ALARM_CNT=4 ignored.

Source files
------------

// File: rtl/alarm_clock_alarm_bank_if.sv
// Write channel into the alarm bank: one slot update per accepted transfer.
// The transfer completes on a clock edge where wr_valid_i && wr_ready_o.
interface alarm_clock_alarm_bank_if #(
  parameter int unsigned TIME_W = 32,
  parameter int unsigned IDX_W  = 2
);
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [IDX_W-1:0]  wr_idx_i;
  logic              wr_unset_i;
  logic [TIME_W-1:0] wr_time_i;

  modport master (
    output wr_valid_i, wr_idx_i, wr_unset_i, wr_time_i,
    input  wr_ready_o
  );

  modport slave (
    input  wr_valid_i, wr_idx_i, wr_unset_i, wr_time_i,
    output wr_ready_o
  );
endinterface

// File: rtl/alarm_clock_alarm_bank.sv
// Multi-slot alarm store: fires per-slot pulses when current time reaches an alarm
// and forwards the earliest pending alarm to the single-alarm POSIX control path.
module alarm_clock_alarm_bank #(
  parameter int unsigned ALARM_CNT = 4,
  parameter int unsigned TIME_W    = 32,
  parameter int unsigned IDX_W     = (ALARM_CNT > 1) ? $clog2(ALARM_CNT) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alarm_clock_alarm_bank_if.slave wr_if,
  input  logic [TIME_W-1:0]    cur_time_i,
  input  logic                 cur_time_val_i,
  output logic [ALARM_CNT-1:0] armed_o,
  output logic [ALARM_CNT-1:0] fire_o,
  output logic [TIME_W-1:0]    usr_posix_time_o,
  output logic                 usr_posix_time_en_o,
  output logic                 usr_unset_alarm_o
);

  localparam int unsigned SCAN_W = (ALARM_CNT > 1) ? $clog2(ALARM_CNT) : 1;
  localparam logic [SCAN_W-1:0] LAST_IDX = SCAN_W'(ALARM_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_UPDATE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [ALARM_CNT-1:0] r_armed, w_armed_nxt;
  logic [TIME_W-1:0]    r_time [ALARM_CNT];
  logic [TIME_W-1:0]    w_time_nxt [ALARM_CNT];
  logic [TIME_W-1:0]    r_cur_time, w_cur_time_nxt;
  logic                 r_pend, w_pend_nxt;
  logic                 r_pushed_vld, w_pushed_vld_nxt;
  logic [SCAN_W-1:0]    r_idx, w_idx_nxt;
  logic [TIME_W-1:0]    r_best, w_best_nxt;
  logic                 r_found, w_found_nxt;
  logic [ALARM_CNT-1:0] r_fire, w_fire_nxt;
  logic                 r_en, w_en_nxt;
  logic                 r_unset, w_unset_nxt;
  logic [TIME_W-1:0]    r_usr_time, w_usr_time_nxt;
  logic                 r_ready;
  logic                 w_sel_armed;
  logic [TIME_W-1:0]    w_sel_time;
  logic [IDX_W-1:0]     w_wr_idx;

  assign w_wr_idx = wr_if.wr_idx_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_armed_nxt      = r_armed;
    w_time_nxt       = r_time;
    w_cur_time_nxt   = r_cur_time;
    w_pend_nxt       = r_pend;
    w_pushed_vld_nxt = r_pushed_vld;
    w_idx_nxt        = r_idx;
    w_best_nxt       = r_best;
    w_found_nxt      = r_found;
    w_fire_nxt       = '0;
    w_en_nxt         = 1'b0;
    w_unset_nxt      = 1'b0;
    w_usr_time_nxt   = r_usr_time;
    w_sel_armed      = 1'b0;
    w_sel_time       = '0;

    for (int unsigned i = 0; i < ALARM_CNT; i++) begin
      if (32'(r_idx) == i) begin
        w_sel_armed = r_armed[i];
        w_sel_time  = r_time[i];
      end
    end

    if (cur_time_val_i) w_cur_time_nxt = cur_time_i;

    unique case (r_state)
      ST_IDLE: begin
        // Out-of-range indices match no slot, so they are accepted and dropped.
        if (wr_if.wr_valid_i) begin
          for (int unsigned i = 0; i < ALARM_CNT; i++) begin
            if (32'(w_wr_idx) == i) begin
              w_armed_nxt[i] = !wr_if.wr_unset_i;
              if (!wr_if.wr_unset_i) w_time_nxt[i] = wr_if.wr_time_i;
            end
          end
        end
        if (wr_if.wr_valid_i || cur_time_val_i || r_pend) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_SCAN;
          w_idx_nxt   = '0;
          w_best_nxt  = '1;
          w_found_nxt = 1'b0;
        end
      end

      ST_SCAN: begin
        if (cur_time_val_i) w_pend_nxt = 1'b1;
        for (int unsigned i = 0; i < ALARM_CNT; i++) begin
          if (32'(r_idx) == i && w_sel_armed && w_sel_time <= r_cur_time) begin
            w_armed_nxt[i] = 1'b0;
            w_fire_nxt[i]  = 1'b1;
          end
        end
        // Strict less-than keeps the lowest index on equal times.
        if (w_sel_armed && w_sel_time > r_cur_time && w_sel_time < r_best) begin
          w_best_nxt  = w_sel_time;
          w_found_nxt = 1'b1;
        end
        if (r_idx == LAST_IDX) w_state_nxt = ST_UPDATE;
        else                   w_idx_nxt   = r_idx + SCAN_W'(1);
      end

      ST_UPDATE: begin
        if (cur_time_val_i) w_pend_nxt = 1'b1;
        if (r_found && (!r_pushed_vld || r_best != r_usr_time)) begin
          w_usr_time_nxt   = r_best;
          w_en_nxt         = 1'b1;
          w_pushed_vld_nxt = 1'b1;
        end else if (!r_found && r_pushed_vld) begin
          w_unset_nxt      = 1'b1;
          w_pushed_vld_nxt = 1'b0;
        end
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_armed      <= '0;
      r_time       <= '{default: '0};
      r_cur_time   <= '0;
      r_pend       <= 1'b0;
      r_pushed_vld <= 1'b0;
      r_idx        <= '0;
      r_best       <= '1;
      r_found      <= 1'b0;
      r_fire       <= '0;
      r_en         <= 1'b0;
      r_unset      <= 1'b0;
      r_usr_time   <= '0;
      r_ready      <= 1'b1;
    end else begin
      r_armed      <= w_armed_nxt;
      r_time       <= w_time_nxt;
      r_cur_time   <= w_cur_time_nxt;
      r_pend       <= w_pend_nxt;
      r_pushed_vld <= w_pushed_vld_nxt;
      r_idx        <= w_idx_nxt;
      r_best       <= w_best_nxt;
      r_found      <= w_found_nxt;
      r_fire       <= w_fire_nxt;
      r_en         <= w_en_nxt;
      r_unset      <= w_unset_nxt;
      r_usr_time   <= w_usr_time_nxt;
      r_ready      <= (w_state_nxt == ST_IDLE);
    end
  end

  assign wr_if.wr_ready_o    = r_ready;
  assign armed_o             = r_armed;
  assign fire_o              = r_fire;
  assign usr_posix_time_o    = r_usr_time;
  assign usr_posix_time_en_o = r_en;
  assign usr_unset_alarm_o   = r_unset;

endmodule

// File: tb/tb_alarm_clock_alarm_bank.sv
// Directed bench for alarm_clock_alarm_bank (4 slots, 3-bit index so idx=5 is reachable).
module tb_alarm_clock_alarm_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cur_time = '0;
  logic        cur_val = 1'b0;
  logic [3:0]  armed, fire;
  logic [31:0] usr_time;
  logic        usr_en, usr_unset;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, en_cnt = 0, unset_cnt = 0, multi_fire = 0, last_en_cyc = 0;
  logic [31:0] last_en_time = '0;
  int fire_cnt [4] = '{default: 0};
  int s_en, s_un, s_cyc;
  int s_fire [4];
  int low;
  bit acc;

  alarm_clock_alarm_bank_if #(.TIME_W(32), .IDX_W(3)) wr_if ();

  alarm_clock_alarm_bank #(.ALARM_CNT(4), .TIME_W(32), .IDX_W(3)) u_dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .wr_if               (wr_if.slave),
    .cur_time_i          (cur_time),
    .cur_time_val_i      (cur_val),
    .armed_o             (armed),
    .fire_o              (fire),
    .usr_posix_time_o    (usr_time),
    .usr_posix_time_en_o (usr_en),
    .usr_unset_alarm_o   (usr_unset)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (usr_en) begin
      en_cnt++;
      last_en_time = usr_time;
      last_en_cyc  = cyc;
    end
    if (usr_unset) unset_cnt++;
    for (int i = 0; i < 4; i++) if (fire[i]) fire_cnt[i]++;
    if ($countones(fire) > 1) multi_fire++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_en   = en_cnt;
    s_un   = unset_cnt;
    s_fire = fire_cnt;
    s_cyc  = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!wr_if.wr_ready_o && n < 40) begin
      tick();
      n++;
    end
    if (!wr_if.wr_ready_o) check("idle_timeout", 0, 1);
  endtask

  task automatic op(input bit wr, input logic [2:0] idx, input bit un, input logic [31:0] t,
                    input bit tv, input logic [31:0] ct);
    wait_idle();
    snap();
    wr_if.wr_valid_i = wr;
    wr_if.wr_idx_i   = idx;
    wr_if.wr_unset_i = un;
    wr_if.wr_time_i  = t;
    cur_val  = tv;
    if (tv) cur_time = ct;
    tick();
    wr_if.wr_valid_i = 1'b0;
    cur_val  = 1'b0;
    wait_idle();
  endtask

  initial begin
    wr_if.wr_valid_i = 1'b0;
    wr_if.wr_idx_i   = '0;
    wr_if.wr_unset_i = 1'b0;
    wr_if.wr_time_i  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_armed", armed, 0);
    check("rst_fire", fire, 0);
    check("rst_en", usr_en, 0);
    check("rst_unset", usr_unset, 0);
    check("rst_ready", wr_if.wr_ready_o, 1);
    check("rst_usr_time", usr_time, 0);

    op(0, 0, 0, 0, 1, 100);
    check("t100_en", en_cnt - s_en, 0);
    check("t100_unset", unset_cnt - s_un, 0);

    op(1, 2, 0, 500, 0, 0);
    check("set2_en", en_cnt - s_en, 1);
    check("set2_time", last_en_time, 500);
    check("set2_latency", last_en_cyc - s_cyc, 6);

    op(1, 0, 0, 300, 0, 0);
    check("set0_en", en_cnt - s_en, 1);
    check("set0_time", last_en_time, 300);
    check("set0_armed", armed, 4'b0101);

    op(0, 0, 0, 0, 1, 300);
    check("t300_fire0", fire_cnt[0] - s_fire[0], 1);
    check("t300_armed", armed, 4'b0100);
    check("t300_en", en_cnt - s_en, 1);
    check("t300_time", last_en_time, 500);

    op(0, 0, 0, 0, 1, 301);
    check("t301_fire2", fire_cnt[2] - s_fire[2], 0);
    check("t301_en", en_cnt - s_en, 0);

    op(1, 2, 1, 0, 0, 0);
    check("unset2_strobe", unset_cnt - s_un, 1);
    check("unset2_armed", armed, 0);
    check("unset2_hold", usr_time, 500);

    op(1, 2, 1, 0, 0, 0);
    check("unset2_again", unset_cnt - s_un, 0);
    check("unset2_again_en", en_cnt - s_en, 0);

    op(1, 1, 0, 700, 0, 0);
    check("set1_en", en_cnt - s_en, 1);
    check("set1_time", last_en_time, 700);
    op(1, 3, 0, 700, 0, 0);
    check("set3_no_en", en_cnt - s_en, 0);
    check("set13_armed", armed, 4'b1010);

    op(0, 0, 0, 0, 1, 800);
    check("t800_fire1", fire_cnt[1] - s_fire[1], 1);
    check("t800_fire3", fire_cnt[3] - s_fire[3], 1);
    check("t800_separate", multi_fire, 0);
    check("t800_unset", unset_cnt - s_un, 1);
    check("t800_armed", armed, 0);

    // A mid-scan time strobe must trigger exactly one extra scan.
    wait_idle();
    snap();
    cur_val = 1'b1; cur_time = 960;
    tick();
    cur_val = 1'b0;
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 1) begin cur_val = 1'b1; cur_time = 970; end
      if (!wr_if.wr_ready_o) low++;
      tick();
      cur_val = 1'b0;
    end
    check("pend_busy_cycles", low, 10);
    check("pend_en", en_cnt - s_en, 0);
    check("pend_unset", unset_cnt - s_un, 0);

    // Held write during a scan is only taken once the bank is idle again.
    wait_idle();
    snap();
    cur_val = 1'b1; cur_time = 980;
    tick();
    cur_val = 1'b0;
    wr_if.wr_valid_i = 1'b1;
    wr_if.wr_idx_i   = 3'd0;
    wr_if.wr_unset_i = 1'b0;
    wr_if.wr_time_i  = 1000;
    low = 0;
    acc = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (wr_if.wr_ready_o) begin
        tick();
        wr_if.wr_valid_i = 1'b0;
        acc = 1'b1;
        break;
      end
      low++;
      if (k == 1) begin cur_val = 1'b1; cur_time = 990; end
      tick();
      cur_val = 1'b0;
    end
    wr_if.wr_valid_i = 1'b0;
    check("held_accepted", acc, 1);
    check("held_ready_low", low, 5);
    wait_idle();
    check("held_en", en_cnt - s_en, 1);
    check("held_time", last_en_time, 1000);
    check("held_armed", armed, 4'b0001);
    check("held_fire0", fire_cnt[0] - s_fire[0], 0);

    op(1, 5, 0, 50, 0, 0);
    check("idx5_armed", armed, 4'b0001);
    check("idx5_en", en_cnt - s_en, 0);
    check("idx5_fire", (fire_cnt[0] + fire_cnt[1] + fire_cnt[2] + fire_cnt[3]) -
                       (s_fire[0] + s_fire[1] + s_fire[2] + s_fire[3]), 0);

    // Reset in the middle of a scan: no fire pulse may escape.
    snap();
    wr_if.wr_valid_i = 1'b1;
    wr_if.wr_idx_i   = 3'd3;
    wr_if.wr_unset_i = 1'b0;
    wr_if.wr_time_i  = 0;
    tick();
    wr_if.wr_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_armed", armed, 0);
    check("midrst_ready", wr_if.wr_ready_o, 1);
    check("midrst_usr_time", usr_time, 0);
    for (int k = 0; k < 8; k++) tick();
    check("midrst_fire3", fire_cnt[3] - s_fire[3], 0);

    op(1, 3, 0, 0, 0, 0);
    check("t0_fire3", fire_cnt[3] - s_fire[3], 1);
    check("t0_armed", armed, 0);
    check("t0_en", en_cnt - s_en, 0);
    check("t0_unset", unset_cnt - s_un, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
